// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that shares a 4-digit BCD display between NUM_REQ sources with a minimum hold time.
// Optional macro SEG_ARB_PREEMPT_EN makes requester 0 a high-priority source that preempts any other owner.
module seg_display_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int HOLD_MS         = 500
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0][3:0][3:0]       req_bcd,
  output logic [NUM_REQ-1:0]                 grant,
  output logic [$clog2(NUM_REQ)-1:0]         owner,
  output logic                               busy,
  output logic [3:0][3:0]                    disp_bcd,
  output logic [1:0]                         dbg_state
);

  localparam int DIV = CLOCK_FREQUENCY / 1000;
  localparam int OW  = $clog2(NUM_REQ);
  localparam int PW  = $clog2(DIV);
  localparam int HW  = $clog2(HOLD_MS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_OPEN = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [OW-1:0]            owner_q, owner_d;
  logic [OW-1:0]            last_owner_q, last_owner_d;
  logic [3:0][3:0]          disp_q, disp_d;
  logic [PW-1:0]            presc_q, presc_d;
  logic [HW-1:0]            hold_q, hold_d;

  logic                     tick;
  logic                     grant_new;
  logic [OW-1:0]            new_owner;
  logic [NUM_REQ-1:0]       others;

  // First set bit of mask scanning upward from last+1 with wrap; last itself is scanned last.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                            input logic [OW-1:0] last);
    logic [OW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && mask[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    presc_d      = presc_q;
    hold_d       = hold_q;
    grant_new    = 1'b0;
    new_owner    = '0;
    tick         = (presc_q == PW'(DIV - 1));
    others       = req & ~grant_q;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        hold_d  = '0;
        if (|req) begin
          grant_new = 1'b1;
`ifdef SEG_ARB_PREEMPT_EN
          new_owner = req[0] ? '0 : rr_pick(req, last_owner_q);
`else
          new_owner = rr_pick(req, last_owner_q);
`endif
        end
      end
      S_HOLD: begin
        if (!req[owner_q]) begin
          state_d = S_IDLE;
        end else if (tick) begin
          presc_d = '0;
          hold_d  = hold_q + HW'(1);
          if (hold_q == HW'(HOLD_MS - 1)) state_d = S_OPEN;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_OPEN: begin
        if (|others) begin
          grant_new = 1'b1;
          new_owner = rr_pick(others, last_owner_q);
        end else if (!req[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SEG_ARB_PREEMPT_EN
    // Preemption overrides both hold timing and an owner drop in the same cycle.
    if (state_q != S_IDLE && owner_q != '0 && req[0]) begin
      grant_new = 1'b1;
      new_owner = '0;
    end
`endif

    if (grant_new) begin
      state_d      = S_HOLD;
      owner_d      = new_owner;
      last_owner_d = new_owner;
      presc_d      = '0;
      hold_d       = '0;
    end

    if (state_d == S_IDLE) owner_d = '0;
    grant_d = (state_d != S_IDLE) ? (NUM_REQ'(1) << owner_d) : '0;
    disp_d  = (state_d != S_IDLE) ? req_bcd[owner_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= OW'(NUM_REQ - 1);
      disp_q       <= '0;
      presc_q      <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      disp_q       <= disp_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);
  assign disp_bcd  = disp_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: a cycle-level reference model pushes expected outputs,
// a monitor pops and compares them one time unit after every rising edge.
module tb_seg_display_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CLKF    = 10000;
  localparam int HOLD_MS = 3;
  localparam int HD      = HOLD_MS * (CLKF / 1000);
  localparam int W       = NUM_REQ + 2 + 1 + 16;

  logic                         clk;
  logic                         rst_i;
  logic [NUM_REQ-1:0]           req_i;
  logic [NUM_REQ-1:0][3:0][3:0] bcd_i;
  logic [NUM_REQ-1:0]           grant_o;
  logic [1:0]                   owner_o;
  logic                         busy_o;
  logic [3:0][3:0]              disp_o;
  logic [1:0]                   state_o;

  seg_display_arbiter #(
    .NUM_REQ(NUM_REQ), .CLOCK_FREQUENCY(CLKF), .HOLD_MS(HOLD_MS)
  ) dut (
    .clk(clk), .rst(rst_i), .req(req_i), .req_bcd(bcd_i),
    .grant(grant_o), .owner(owner_o), .busy(busy_o), .disp_bcd(disp_o),
    .dbg_state(state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit rand_bcd = 1'b0;

  // Reference model: owner (-1 = idle), last owner, edges since the last grant change
  int m_owner = -1;
  int m_last  = NUM_REQ - 1;
  int m_cnt   = 0;

  function automatic int rr(input logic [NUM_REQ-1:0] m, input int last);
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (last + i) % NUM_REQ;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [NUM_REQ-1:0] rq,
                            input logic [NUM_REQ-1:0][3:0][3:0] bcd);
    int cand;
    logic [NUM_REQ-1:0] oth;
    logic [NUM_REQ-1:0] g;
    cand = -1;
    if (r) begin
      m_owner = -1;
      m_last  = NUM_REQ - 1;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      if (rq != 0) cand = rr(rq, m_last);
`ifdef SEG_ARB_PREEMPT_EN
      if (rq[0]) cand = 0;
`endif
    end else begin
      m_cnt++;
`ifdef SEG_ARB_PREEMPT_EN
      if (m_owner != 0 && rq[0]) cand = 0;
`endif
      if (cand < 0) begin
        if (m_cnt <= HD) begin
          if (!rq[m_owner]) m_owner = -1;
        end else begin
          oth = rq;
          oth[m_owner] = 1'b0;
          if (oth != 0) cand = rr(oth, m_last);
          else if (!rq[m_owner]) m_owner = -1;
        end
      end
    end
    if (cand >= 0) begin
      m_owner = cand;
      m_last  = cand;
      m_cnt   = 0;
    end
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    exp_q.push_back({g, 2'(m_owner >= 0 ? m_owner : 0), m_owner >= 0,
                     (m_owner >= 0) ? bcd[m_owner] : 16'h0000});
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] v;
    for (int d = 0; d < 4; d++) v[d*4 +: 4] = 4'($urandom_range(9));
    return v;
  endfunction

  // Driver: inputs change on the falling edge, the model predicts the next rising edge
  task automatic drive(input logic r, input logic [NUM_REQ-1:0] rq);
    int k;
    @(negedge clk);
    if (rand_bcd && $urandom_range(3) == 0) begin
      k = $urandom_range(NUM_REQ - 1);
      bcd_i[k] = rand_word();
    end
    rst_i = r;
    req_i = rq;
    model_edge(r, rq, bcd_i);
  endtask

  task automatic run(input logic [NUM_REQ-1:0] rq, input int n);
    repeat (n) drive(1'b0, rq);
  endtask

  // Monitor
  initial begin
    logic [W-1:0] exp_v, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got   = {grant_o, owner_o, busy_o, disp_o};
        n_checks++;
        if (got === exp_v) n_pass++;
        else $display("FAIL out_check t=%0t got grant=%b owner=%0d busy=%b disp=%h required grant=%b owner=%0d busy=%b disp=%h",
                      $time, got[W-1 -: 4], got[18:17], got[16], got[15:0],
                      exp_v[W-1 -: 4], exp_v[18:17], exp_v[16], exp_v[15:0]);
      end
    end
  end

  // Stimulus
  initial begin
    int total;
    logic [NUM_REQ-1:0] rq;
    int len;
    logic r;
    rst_i = 1'b1;
    req_i = '0;
    bcd_i = '0;

    repeat (3) drive(1'b1, 4'b0000);

    // Post-reset grant and live digit update
    @(negedge clk);
    bcd_i[2] = 16'h1234;
    rst_i = 1'b0;
    req_i = 4'b0100;
    model_edge(1'b0, 4'b0100, bcd_i);
    run(4'b0100, 2);
    @(negedge clk);
    bcd_i[2] = 16'h5678;
    model_edge(1'b0, 4'b0100, bcd_i);
    run(4'b0100, 3);
    run(4'b0000, 2);

    rand_bcd = 1'b1;
    // Rotation 0,1,2,3,0 with no idle gaps
    drive(1'b1, 4'b0000);
    run(4'b1111, 4 * (HD + 1) + 5);

    // Early release of owner 1 while 3 waits
    drive(1'b1, 4'b0000);
    run(4'b0010, 2);
    run(4'b1010, 4);
    run(4'b1000, 6);

    // Sole requester stays in OPEN
    drive(1'b1, 4'b0000);
    run(4'b0100, 200);

    // Mid-operation reset during OPEN
    drive(1'b1, 4'b0000);
    run(4'b0100, HD + 10);
    drive(1'b1, 4'b0110);
    run(4'b0110, 5);

    // Requester 0 appears while 2 is holding, with 3 also pending
    drive(1'b1, 4'b0000);
    run(4'b0100, 4);
    run(4'b1101, HD + 10);
    run(4'b1100, 2 * HD);

    // Random phases
    total = 0;
    while (total < 3000) begin
      r   = ($urandom_range(15) == 0);
      rq  = 4'($urandom_range(15));
      len = $urandom_range(1, 80);
      drive(r, rq);
      run(rq, len - 1);
      total += len;
    end

    run(4'b0000, 2);
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain got %0d pending entries, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
